// File: rtl/ai3c_lane_pkg.sv
// Shared types and helpers for the I3C lane serializer.
package ai3c_lane_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLow,
    StHigh,
    StNinthLow,
    StNinthHigh,
    StDone
  } lane_state_e;

  // Odd parity (T-bit): 1 when the word has an even number of ones.
  // Callers zero-extend the word, which does not change its parity.
  function automatic logic odd_parity(input logic [63:0] d);
    return ~^d;
  endfunction

  // Phase lengths of 0 behave as 1 cycle.
  function automatic logic [31:0] clamp1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/ai3c_scl_timer.sv
// SCL phase down-counter: load a length-1 value, expired_o is high once it reaches 0.
module ai3c_scl_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load on phase entry, otherwise count down and hold at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ai3c_lane_serializer.sv
// Multi-lane I3C SDA/SCL serializer: drives SCL, shifts words MSB-first across the lanes,
// samples the lanes on each SCL rise and optionally runs a 9th-bit (T-bit/ACK) phase.
module ai3c_lane_serializer
  import ai3c_lane_pkg::*;
#(
  parameter int unsigned LANE_NUM = 1,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CNT_W-1:0]    cfg_t_low,
  input  logic [CNT_W-1:0]    cfg_t_high,
  input  logic                cfg_od_mode,
  input  logic                cfg_ninth_en,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [DATA_W-1:0]   tx_data,
  output logic                rx_valid,
  output logic [DATA_W-1:0]   rx_data,
  output logic                rx_ninth,
  output logic                busy,
  output logic                scl_o,
  output logic [LANE_NUM-1:0] sda_o,
  output logic [LANE_NUM-1:0] sda_oe,
  input  logic [LANE_NUM-1:0] sda_i
);

  if (DATA_W % LANE_NUM != 0) begin : g_bad_width
    $fatal(1, "DATA_W must be a multiple of LANE_NUM");
  end

  localparam int unsigned NumBeats = DATA_W / LANE_NUM;
  localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;

  lane_state_e         state_q;
  logic [DATA_W-1:0]   data_q, rx_sh_q, rx_sh_d, data_shl, rx_data_q;
  logic [CNT_W-1:0]    tl_q, th_q, timer_val;
  logic [BeatW-1:0]    beat_q;
  logic [LANE_NUM-1:0] beat_first, beat_next, sda_o_q, sda_oe_q;
  logic                od_q, ninth_q, par_q, first_q, nin_q, nin_d;
  logic                scl_q, ready_q, busy_q, rx_valid_q, rx_ninth_q;
  logic                accept, timer_load, expired;

  // Beat slices, receive shift and handshake decode.
  always_comb begin
    accept     = (state_q == StIdle) && tx_valid;
    data_shl   = data_q << LANE_NUM;
    beat_first = tx_data[DATA_W-1 -: LANE_NUM];
    beat_next  = data_shl[DATA_W-1 -: LANE_NUM];
    rx_sh_d    = rx_sh_q;
    nin_d      = nin_q;
    if (state_q == StHigh && first_q) rx_sh_d = (rx_sh_q << LANE_NUM) | DATA_W'(sda_i);
    if (state_q == StNinthHigh && first_q) nin_d = sda_i[0];
  end

  // Timer reload on accept and at the end of every SCL phase.
  always_comb begin
    timer_load = accept;
    if (state_q inside {StLow, StHigh, StNinthLow, StNinthHigh}) timer_load = expired;
    case (state_q)
      StIdle:             timer_val = CNT_W'(clamp1(32'(cfg_t_low)) - 32'd1);
      StLow, StNinthLow:  timer_val = th_q - CNT_W'(1);
      default:            timer_val = tl_q - CNT_W'(1);
    endcase
  end

  ai3c_scl_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .expired_o (expired)
  );

  // Transfer sequencer with registered bus and handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      data_q     <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      tl_q       <= CNT_W'(1);
      th_q       <= CNT_W'(1);
      beat_q     <= '0;
      od_q       <= 1'b0;
      ninth_q    <= 1'b0;
      par_q      <= 1'b0;
      first_q    <= 1'b0;
      nin_q      <= 1'b0;
      scl_q      <= 1'b1;
      sda_o_q    <= '0;
      sda_oe_q   <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_ninth_q <= 1'b0;
    end else begin
      first_q    <= timer_load;
      rx_valid_q <= 1'b0;
      rx_sh_q    <= rx_sh_d;
      nin_q      <= nin_d;
      case (state_q)
        StIdle: if (accept) begin
          data_q   <= tx_data;
          tl_q     <= CNT_W'(clamp1(32'(cfg_t_low)));
          th_q     <= CNT_W'(clamp1(32'(cfg_t_high)));
          od_q     <= cfg_od_mode;
          ninth_q  <= cfg_ninth_en;
          par_q    <= odd_parity(64'(tx_data));
          beat_q   <= '0;
          state_q  <= StLow;
          scl_q    <= 1'b0;
          sda_o_q  <= cfg_od_mode ? '0 : beat_first;
          sda_oe_q <= cfg_od_mode ? ~beat_first : '1;
          ready_q  <= 1'b0;
          busy_q   <= 1'b1;
        end
        StLow, StNinthLow: if (expired) begin
          state_q <= (state_q == StLow) ? StHigh : StNinthHigh;
          scl_q   <= 1'b1;
        end
        StHigh, StNinthHigh: if (expired) begin
          if (state_q == StHigh && beat_q != BeatW'(NumBeats - 1)) begin
            beat_q   <= beat_q + BeatW'(1);
            data_q   <= data_shl;
            state_q  <= StLow;
            scl_q    <= 1'b0;
            sda_o_q  <= od_q ? '0 : beat_next;
            sda_oe_q <= od_q ? ~beat_next : '1;
          end else if (state_q == StHigh && ninth_q) begin
            // Push-pull drives the T-bit on lane 0; open-drain releases for the ACK.
            state_q  <= StNinthLow;
            scl_q    <= 1'b0;
            sda_o_q  <= od_q ? '0 : LANE_NUM'(par_q);
            sda_oe_q <= od_q ? '0 : LANE_NUM'(1);
          end else begin
            state_q    <= StDone;
            scl_q      <= 1'b1;
            sda_o_q    <= '0;
            sda_oe_q   <= '0;
            rx_valid_q <= 1'b1;
            rx_data_q  <= rx_sh_d;
            rx_ninth_q <= ninth_q & nin_d;
          end
        end
        StDone: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_ninth = rx_ninth_q;
  assign scl_o    = scl_q;
  assign sda_o    = sda_o_q;
  assign sda_oe   = sda_oe_q;

endmodule

// File: tb/tb_ai3c_lane_serializer.sv
// Directed bench: single-lane and four-lane serializers on loopback buses.
module tb_ai3c_lane_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Single-lane instance, bus resolves to drive value or pull-up, target may pull low.
  logic [7:0] t_low1, t_high1, tx_data1, rx_data1;
  logic       od1, nin_en1, tx_valid1, tx_ready1, rx_valid1, rx_ninth1, busy1, scl1;
  logic [0:0] sda_o1, sda_oe1, sda_i1;
  logic       pull;
  assign sda_i1 = ((sda_o1 & sda_oe1) | ~sda_oe1) & ~pull;

  ai3c_lane_serializer #(.LANE_NUM(1), .DATA_W(8), .CNT_W(8)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .cfg_t_low(t_low1), .cfg_t_high(t_high1),
    .cfg_od_mode(od1), .cfg_ninth_en(nin_en1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .tx_data(tx_data1), .rx_valid(rx_valid1), .rx_data(rx_data1), .rx_ninth(rx_ninth1),
    .busy(busy1), .scl_o(scl1), .sda_o(sda_o1), .sda_oe(sda_oe1), .sda_i(sda_i1)
  );

  // Four-lane instance on a plain loopback bus.
  logic [7:0] t_low4, t_high4, tx_data4, rx_data4;
  logic       od4, nin_en4, tx_valid4, tx_ready4, rx_valid4, rx_ninth4, busy4, scl4;
  logic [3:0] sda_o4, sda_oe4, sda_i4;
  assign sda_i4 = (sda_o4 & sda_oe4) | ~sda_oe4;

  ai3c_lane_serializer #(.LANE_NUM(4), .DATA_W(8), .CNT_W(8)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .cfg_t_low(t_low4), .cfg_t_high(t_high4),
    .cfg_od_mode(od4), .cfg_ninth_en(nin_en4), .tx_valid(tx_valid4), .tx_ready(tx_ready4),
    .tx_data(tx_data4), .rx_valid(rx_valid4), .rx_data(rx_data4), .rx_ninth(rx_ninth4),
    .busy(busy4), .scl_o(scl4), .sda_o(sda_o4), .sda_oe(sda_oe4), .sda_i(sda_i4)
  );

  // One single-lane transfer; beat k is recorded in bit 7-k, p is the SCL period.
  task automatic xfer(input logic [7:0] d, input logic od, input logic nin,
                      input logic [7:0] tl, input logic [7:0] th, input int p,
                      output logic [7:0] so, output logic [7:0] oe, output logic t_o,
                      output logic t_oe, output int vc, output logic [7:0] rd,
                      output logic rn, output logic s1, output logic s2, output logic rv_next);
    so = '0; oe = '0; t_o = 1'b0; t_oe = 1'b0; vc = -1; rd = '0; rn = 1'b0;
    s1 = 1'b1; s2 = 1'b0; rv_next = 1'b1;
    @(negedge clk);
    t_low1 = tl; t_high1 = th; od1 = od; nin_en1 = nin; tx_data1 = d; tx_valid1 = 1'b1;
    @(posedge clk);
    #1 tx_valid1 = 1'b0;
    for (int c = 1; c <= 200 && vc < 0; c++) begin
      @(negedge clk);
      pull = od && nin && (c >= 1 + 8 * p) && (c < 1 + 9 * p);
      if (c == 1) s1 = scl1;
      if (c == 2) s2 = scl1;
      for (int k = 0; k < 8; k++) begin
        if (c == 1 + k * p) begin
          so[7-k] = sda_o1[0];
          oe[7-k] = sda_oe1[0];
        end
      end
      if (c == 1 + 8 * p) begin
        t_o  = sda_o1[0];
        t_oe = sda_oe1[0];
      end
      if (rx_valid1) begin
        vc = c; rd = rx_data1; rn = rx_ninth1;
      end
    end
    pull = 1'b0;
    @(negedge clk);
    rv_next = rx_valid1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (scl1 !== 1'b1 || sda_o1 !== 1'b0 || sda_oe1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus scl=%b sda_o=%b sda_oe=%b required 1 0 0", scl1, sda_o1, sda_oe1);
    end
    checks++;
    if (tx_ready1 !== 1'b1 || busy1 !== 1'b0 || rx_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs ready=%b busy=%b rx_valid=%b required 1 0 0",
               tx_ready1, busy1, rx_valid1);
    end
    checks++;
    if (rx_data1 !== 8'h00 || rx_ninth1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_rx rx_data=%h rx_ninth=%b required 00 0", rx_data1, rx_ninth1);
    end
  endtask

  task automatic test_push_pull();
    logic [7:0] so, oe, rd;
    logic t_o, t_oe, rn, s1, s2, rvn;
    int vc;
    xfer(8'hA5, 1'b0, 1'b1, 8'd2, 8'd2, 4, so, oe, t_o, t_oe, vc, rd, rn, s1, s2, rvn);
    checks++;
    if (so !== 8'hA5 || oe !== 8'hFF) begin
      errors++;
      $display("FAIL pp_beats sda_o=%h sda_oe=%h required a5 ff", so, oe);
    end
    checks++;
    if (t_o !== 1'b1 || t_oe !== 1'b1) begin
      errors++;
      $display("FAIL pp_tbit o=%b oe=%b required 1 1", t_o, t_oe);
    end
    checks++;
    if (vc != 37) begin
      errors++;
      $display("FAIL pp_latency rx_valid cycle=%0d required 37", vc);
    end
    checks++;
    if (rd !== 8'hA5 || rn !== 1'b1) begin
      errors++;
      $display("FAIL pp_rx rx_data=%h rx_ninth=%b required a5 1", rd, rn);
    end
    checks++;
    if (rvn !== 1'b0 || s1 !== 1'b0 || s2 !== 1'b0) begin
      errors++;
      $display("FAIL pp_pulse rx_valid_next=%b scl_c1=%b scl_c2=%b required 0 0 0", rvn, s1, s2);
    end
  endtask

  task automatic test_open_drain();
    logic [7:0] so, oe, rd;
    logic t_o, t_oe, rn, s1, s2, rvn;
    int vc;
    xfer(8'h7E, 1'b1, 1'b1, 8'd2, 8'd2, 4, so, oe, t_o, t_oe, vc, rd, rn, s1, s2, rvn);
    checks++;
    if (oe !== 8'h81 || so !== 8'h00) begin
      errors++;
      $display("FAIL od_beats sda_oe=%h sda_o=%h required 81 00", oe, so);
    end
    checks++;
    if (t_oe !== 1'b0) begin
      errors++;
      $display("FAIL od_release ninth sda_oe=%b required 0", t_oe);
    end
    checks++;
    if (vc != 37 || rd !== 8'h7E || rn !== 1'b0) begin
      errors++;
      $display("FAIL od_rx cycle=%0d rx_data=%h rx_ninth=%b required 37 7e 0", vc, rd, rn);
    end
  endtask

  task automatic test_zero_phase();
    logic [7:0] so, oe, rd;
    logic t_o, t_oe, rn, s1, s2, rvn;
    int vc;
    xfer(8'h5A, 1'b0, 1'b0, 8'd0, 8'd0, 2, so, oe, t_o, t_oe, vc, rd, rn, s1, s2, rvn);
    checks++;
    if (s1 !== 1'b0 || s2 !== 1'b1) begin
      errors++;
      $display("FAIL zero_scl scl_c1=%b scl_c2=%b required 0 1", s1, s2);
    end
    checks++;
    if (vc != 17) begin
      errors++;
      $display("FAIL zero_latency rx_valid cycle=%0d required 17", vc);
    end
    checks++;
    if (rd !== 8'h5A || rn !== 1'b0 || so !== 8'h5A) begin
      errors++;
      $display("FAIL zero_rx rx_data=%h rx_ninth=%b beats=%h required 5a 0 5a", rd, rn, so);
    end
  endtask

  task automatic test_four_lane();
    logic [3:0] b0, b1, oe0;
    logic [7:0] rd;
    int vc = -1;
    b0 = '0; b1 = '0; oe0 = '0; rd = '0;
    @(negedge clk);
    t_low4 = 8'd3; t_high4 = 8'd1; od4 = 1'b0; nin_en4 = 1'b0; tx_data4 = 8'h3C;
    tx_valid4 = 1'b1;
    @(posedge clk);
    #1 tx_valid4 = 1'b0;
    for (int c = 1; c <= 50 && vc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin b0 = sda_o4; oe0 = sda_oe4; end
      if (c == 5) b1 = sda_o4;
      if (rx_valid4) begin vc = c; rd = rx_data4; end
    end
    checks++;
    if (b0 !== 4'h3 || b1 !== 4'hC || oe0 !== 4'hF) begin
      errors++;
      $display("FAIL lane4_beats b0=%h b1=%h oe=%h required 3 c f", b0, b1, oe0);
    end
    checks++;
    if (vc != 9 || rd !== 8'h3C || rx_ninth4 !== 1'b0) begin
      errors++;
      $display("FAIL lane4_rx cycle=%0d rx_data=%h ninth=%b required 9 3c 0", vc, rd, rx_ninth4);
    end
  endtask

  task automatic test_mid_reset();
    int nvalid = 0;
    @(negedge clk);
    t_low1 = 8'd2; t_high1 = 8'd2; od1 = 1'b0; nin_en1 = 1'b1; tx_data1 = 8'hA5;
    tx_valid1 = 1'b1;
    @(posedge clk);
    #1 tx_valid1 = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (scl1 !== 1'b1 || sda_oe1 !== 1'b0 || tx_ready1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_bus scl=%b oe=%b ready=%b busy=%b required 1 0 1 0",
               scl1, sda_oe1, tx_ready1, busy1);
    end
    checks++;
    if (rx_data1 !== 8'h00) begin
      errors++;
      $display("FAIL midrst_rx rx_data=%h required 00", rx_data1);
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (rx_valid1) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL midrst_novalid rx_valid pulses=%0d required 0", nvalid);
    end
  endtask

  task automatic test_back_to_back();
    int acc[2];
    int dn[2];
    logic [7:0] rdat[2];
    int nacc = 0;
    int ndone = 0;
    acc[0] = -1; acc[1] = -1; dn[0] = -1; dn[1] = -1; rdat[0] = '0; rdat[1] = '0;
    @(negedge clk);
    t_low1 = 8'd1; t_high1 = 8'd1; od1 = 1'b0; nin_en1 = 1'b0; tx_data1 = 8'h11;
    tx_valid1 = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (c > 0) @(negedge clk);
      if (rx_valid1 && ndone < 2) begin
        dn[ndone] = c; rdat[ndone] = rx_data1; ndone++;
      end
      if (tx_ready1 && tx_valid1) begin
        if (nacc < 2) acc[nacc] = c;
        nacc++;
        @(posedge clk);
        #1;
        if (nacc == 1) tx_data1 = 8'h22;
        else tx_valid1 = 1'b0;
      end
    end
    tx_valid1 = 1'b0;
    checks++;
    if (nacc != 2 || ndone != 2) begin
      errors++;
      $display("FAIL b2b_count accepts=%0d dones=%0d required 2 2", nacc, ndone);
    end
    checks++;
    if (acc[1] != dn[0] + 1 || dn[0] != acc[0] + 17 || dn[1] != acc[1] + 17) begin
      errors++;
      $display("FAIL b2b_timing acc=%0d,%0d done=%0d,%0d required done=acc+17, acc1=done0+1",
               acc[0], acc[1], dn[0], dn[1]);
    end
    checks++;
    if (rdat[0] !== 8'h11 || rdat[1] !== 8'h22) begin
      errors++;
      $display("FAIL b2b_data rx=%h,%h required 11,22", rdat[0], rdat[1]);
    end
  endtask

  initial begin
    t_low1 = '0; t_high1 = '0; od1 = 1'b0; nin_en1 = 1'b0; tx_valid1 = 1'b0; tx_data1 = '0;
    t_low4 = '0; t_high4 = '0; od4 = 1'b0; nin_en4 = 1'b0; tx_valid4 = 1'b0; tx_data4 = '0;
    pull = 1'b0;
    test_reset();
    test_push_pull();
    test_open_drain();
    test_zero_phase();
    test_four_lane();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ai3c_lane_serializer.md
Name: ai3c_lane_serializer

Overview:
Clocked multi-lane I3C bus-side serializer/deserializer. It replaces the static, tri-state-only lane driver with a sequenced engine. For each accepted word it:
- generates SCL with programmable low/high phases;
- shifts the word MSB-first across LANE_NUM SDA lanes in open-drain or push-pull mode;
- samples the lanes on each SCL rising edge;
- optionally runs a 9th-bit phase (T-bit or ACK).

It sits between the testbench/controller transaction layer and the bus pad wrapper that resolves the wired-AND SDA/SCL nets.

Parameters:
- LANE_NUM, 1, number of SDA lanes; bits moved per SCL period.
- DATA_W, 8, word width; DATA_W % LANE_NUM == 0, otherwise fatal elaboration error.
- CNT_W, 8, width of the SCL phase counters.

Ports:
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- cfg_t_low  in  CNT_W  SCL low phase in clk_i cycles; 0 is treated as 1.
- cfg_t_high  in  CNT_W  SCL high phase in clk_i cycles; 0 is treated as 1.
- cfg_od_mode  in  1  1 = open-drain, 0 = push-pull.
- cfg_ninth_en  in  1  append 9th-bit phase.
- tx_valid  in  1  word offered.
- tx_ready  out  1  high only in IDLE.
- tx_data  in  DATA_W  word to send.
- rx_valid  out  1  one-cycle pulse, transfer complete.
- rx_data  out  DATA_W  sampled word.
- rx_ninth  out  1  sda_i[0] sampled in the 9th phase; 0 if the phase is disabled.
- busy  out  1  state != IDLE.
- scl_o  out  1  SCL drive.
- sda_o  out  LANE_NUM  SDA drive value.
- sda_oe  out  LANE_NUM  SDA drive enable.
- sda_i  in  LANE_NUM  resolved SDA bus value.

Behaviour:
- Interface timing: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: state IDLE, scl_o=1, sda_o=0, sda_oe=0, tx_ready=1, busy=0, rx_valid=0, rx_data=0, rx_ninth=0.
- Reset asserted mid-transfer: same values on the next edge; no rx_valid; in-flight word dropped.
- Accept: handshake when tx_valid & tx_ready in IDLE.
  - tx_data, cfg_* (with 0→1 clamp) are latched on that edge.
  - Beat counter cleared; next state is LOW.
  - cfg_* changes during a transfer are ignored.
- Beats: N = DATA_W/LANE_NUM. Beat k drives tx_data[DATA_W-1-k*LANE_NUM -: LANE_NUM]; lane LANE_NUM-1 carries the most significant bit.
- States and transitions:
  - IDLE: waits for accept.
  - LOW: scl_o=0 for TL cycles. Lane outputs update on the first LOW cycle of each beat.
  - HIGH: scl_o=1 for TH cycles.
    - First HIGH cycle: shift sda_i into the rx shift register (MSB-first, same lane mapping).
    - Last HIGH cycle: if k<N-1, k++ and go to LOW; else go to NINTH_LOW if ninth enabled, else DONE.
  - NINTH_LOW, then NINTH_HIGH: TL and TH cycles; sda_i[0] captured into rx_ninth on the first NINTH_HIGH cycle.
    - Push-pull: lane0 drives the T-bit = ~^data (odd parity) with oe=1; other lanes oe=0.
    - Open-drain: all lanes oe=0 (released for target ACK).
  - DONE: one cycle; rx_valid=1; rx_data/rx_ninth hold until the next DONE; scl_o=1, sda_oe=0; next state IDLE.
- Lane drive per bit b:
  - Open-drain: sda_o=0, sda_oe=~b.
  - Push-pull: sda_o=b, sda_oe=1.
- Latency: with accept at cycle 0, rx_valid is asserted at cycle 1 + (N + cfg_ninth_en) × (TL + TH).
- Back-pressure: tx_valid while busy is not consumed. The earliest next accept is the cycle after DONE, so words are never merged.
- Counters: the phase counter loads TL-1 or TH-1 and counts down to 0, with no wrap.

Decomposition:
- Package ai3c_lane_pkg:
  - state enum (IDLE, LOW, HIGH, NINTH_LOW, NINTH_HIGH, DONE);
  - odd-parity function;
  - clamp-to-1 function.
- Sub-module ai3c_scl_timer: phase down-counter with load/expire pulse; shared by LOW/HIGH/NINTH states.

Test Plan:
- Push-pull SDR, LANE_NUM=1, DATA_W=8, TL=TH=2, ninth on, loopback, tx 0xA5:
  - sda_o sequence 1,0,1,0,0,1,0,1, then T=1;
  - rx_valid at cycle 37; rx_data=0xA5, rx_ninth=1.
- Open-drain, tx 0x7E, sda_i = wired-AND of the outputs, target pulls lane0 low in the 9th phase:
  - sda_oe per beat 1,0,0,0,0,0,0,1;
  - rx_data=0x7E, rx_ninth=0 (ACK).
- LANE_NUM=4, DATA_W=8, TL=3, TH=1, ninth off, tx 0x3C:
  - beats 0x3 then 0xC;
  - rx_valid at cycle 9.
- TL=TH=0, LANE_NUM=1, ninth off: SCL period is 2 cycles; rx_valid at cycle 17.
- rst_i pulsed at cycle 10 of a transfer: next cycle scl_o=1, sda_oe=0, tx_ready=1; no rx_valid ever.
- tx_valid held continuously with 0x11 then 0x22: exactly two accepts, each one cycle after the preceding DONE; rx_data 0x11 then 0x22.
